// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Seven-segment constants and hex-to-segment helper function.
//            Segment order is {g,f,e,d,c,b,a}; a 1 lights the segment.
// Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Standard hex glyphs; lower-case b and d keep them distinct from 8 and 0.
  function automatic logic [6:0] hex_to_seg7(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      4'hF:    seg = 7'b1110001;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg7
// Brief    : Purely combinational 4-bit hex to seven-segment decoder.
// Revision : 1.0  initial release
// ============================================================================
module hex_to_seg7 (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // Decode through the shared package table so every user sees identical glyphs.
  always_comb begin
    o_seg = seg7_pkg::hex_to_seg7(i_hex);
  end

endmodule
`default_nettype wire

// File: rtl/cyclic_fifo_7seg.sv
`default_nettype none
// ============================================================================
// Module   : cyclic_fifo_7seg
// Brief    : Circular buffer filled/drained by push/pop buttons (rising-edge
//            events), with full/empty, optional overwrite-oldest, sticky
//            overflow/underflow and a registered seven-segment view of the
//            entry at the read pointer.
// Revision : 1.0  initial release
// ============================================================================
module cyclic_fifo_7seg
  import seg7_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 8,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       btn_push,
  input  logic                       btn_pop,
  input  logic [WIDTH-1:0]           data_in,
  output logic [6:0]                 segments,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               push_q, push_d;
  logic               pop_q, pop_d;
  logic [6:0]         seg_q, seg_d;

  logic               w_push_ev;
  logic               w_pop_ev;
  logic               w_full;
  logic               w_empty;
  logic [3:0]         w_nibble;
  logic [6:0]         w_dec_seg;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Status flags and single-shot button events.
  always_comb begin
    w_full    = (count_q == c_cnt_w'(DEPTH));
    w_empty   = (count_q == '0);
    w_push_ev = btn_push & ~push_q;
    w_pop_ev  = btn_pop & ~pop_q;
    w_nibble  = 4'(mem_q[rd_ptr_q]);
  end

  hex_to_seg7 u_dec (
    .i_hex (w_nibble),
    .o_seg (w_dec_seg)
  );

  // Next buffer state from the push/pop events; a simultaneous pair keeps count.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push_d      = btn_push;
    pop_d       = btn_pop;
    if (w_push_ev && w_pop_ev) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      if (w_empty) begin
        // Nothing to pop yet: the push lands, the pop is reported as underflow.
        count_d     = count_q + 1'b1;
        underflow_d = 1'b1;
      end else begin
        // When full, wr_ptr == rd_ptr, so the slot being read is the one refilled.
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
    end else if (w_push_ev) begin
      if (!w_full) begin
        mem_d[wr_ptr_q] = data_in;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
        count_d         = count_q + 1'b1;
      end else if (OVERWRITE) begin
        mem_d[wr_ptr_q] = data_in;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
        rd_ptr_d        = ptr_inc(rd_ptr_q);
      end else begin
        overflow_d = 1'b1;
      end
    end else if (w_pop_ev) begin
      if (!w_empty) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d  = count_q - 1'b1;
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  // Display follows the current head one cycle later; dash while nothing is stored.
  always_comb begin
    seg_d = w_empty ? SEG_DASH : w_dec_seg;
  end

  // State registers; button history reloads on reset so a held button cannot fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      push_q      <= btn_push;
      pop_q       <= btn_pop;
      seg_q       <= SEG_DASH;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      seg_q       <= seg_d;
    end
  end

  assign segments  = seg_q;
  assign count     = count_q;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cyclic_fifo_7seg.sv
`default_nettype none
// ============================================================================
// Module   : tb_cyclic_fifo_7seg
// Brief    : Self-checking bench driving a drop-on-full and an overwrite-oldest
//            instance (DEPTH=4, WIDTH=4) with the same button stimulus and
//            comparing both against queue-based reference models.
// Revision : 1.0  initial release
// ============================================================================
module tb_cyclic_fifo_7seg;

  localparam int DEPTH = 4;
  localparam int WIDTH = 4;
  localparam logic [6:0] DASH = 7'b1000000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             btn_push = 1'b0;
  logic             btn_pop = 1'b0;
  logic [WIDTH-1:0] data_in = '0;

  logic [6:0] seg0, seg1;
  logic [2:0] cnt0, cnt1;
  logic       full0, full1, empty0, empty1, ovf0, ovf1, unf0, unf1;

  int checks = 0;
  int errors = 0;

  // Reference model: queue head is the oldest entry.
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  bit         m_ovf0, m_ovf1, m_unf0, m_unf1;
  bit         prev_push, prev_pop;
  logic [6:0] eseg0, eseg1;

  cyclic_fifo_7seg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVERWRITE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .btn_push(btn_push), .btn_pop(btn_pop),
    .data_in(data_in), .segments(seg0), .count(cnt0), .full(full0),
    .empty(empty0), .overflow(ovf0), .underflow(unf0)
  );

  cyclic_fifo_7seg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVERWRITE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .btn_push(btn_push), .btn_pop(btn_pop),
    .data_in(data_in), .segments(seg1), .count(cnt1), .full(full1),
    .empty(empty1), .overflow(ovf1), .underflow(unf1)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
          7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
          7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
          7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
    return t[v];
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit.
  task automatic tick(input bit p, input bit o, input logic [3:0] d, input bit r);
    bit pe, oe;
    btn_push = p; btn_pop = o; data_in = d; reset = r;
    @(posedge clk);
    eseg0 = (r || q0.size() == 0) ? DASH : ref_seg(q0[0]);
    eseg1 = (r || q1.size() == 0) ? DASH : ref_seg(q1[0]);
    if (r) begin
      q0.delete(); q1.delete();
      m_ovf0 = 0; m_ovf1 = 0; m_unf0 = 0; m_unf1 = 0;
    end else begin
      pe = p && !prev_push;
      oe = o && !prev_pop;
      if (pe && oe) begin
        if (q0.size() == 0) begin q0.push_back(d); m_unf0 = 1; end
        else begin void'(q0.pop_front()); q0.push_back(d); end
        if (q1.size() == 0) begin q1.push_back(d); m_unf1 = 1; end
        else begin void'(q1.pop_front()); q1.push_back(d); end
      end else if (pe) begin
        if (q0.size() < DEPTH) q0.push_back(d);
        else m_ovf0 = 1;
        if (q1.size() < DEPTH) q1.push_back(d);
        else begin void'(q1.pop_front()); q1.push_back(d); end
      end else if (oe) begin
        if (q0.size() > 0) void'(q0.pop_front()); else m_unf0 = 1;
        if (q1.size() > 0) void'(q1.pop_front()); else m_unf1 = 1;
      end
    end
    prev_push = p;
    prev_pop  = o;
    #1;
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    checks++; if (seg0 !== 7'b1000000) begin errors++; $display("FAIL reset_seg: got %b want 1000000", seg0); end
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cnt0); end
    checks++; if (empty0 !== 1'b1 || full0 !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got empty=%b full=%b want 1/0", empty0, full0); end
    checks++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0/0", ovf0, unf0); end
    checks++; if (seg1 !== 7'b1000000 || cnt1 !== 3'd0) begin errors++; $display("FAIL reset_dut1: got seg=%b cnt=%0d want 1000000/0", seg1, cnt1); end
  endtask

  task automatic test_single_push();
    tick(1, 0, 4'd5, 0);
    checks++; if (cnt0 !== 3'd1) begin errors++; $display("FAIL push_count: got %0d want 1", cnt0); end
    checks++; if (seg0 !== DASH) begin errors++; $display("FAIL push_seg_lag: got %b want %b", seg0, DASH); end
    tick(0, 0, 4'd0, 0);
    checks++; if (seg0 !== 7'b1101101) begin errors++; $display("FAIL push_seg: got %b want 1101101", seg0); end
  endtask

  task automatic test_fill_overflow();
    logic [3:0] vals [5];
    logic [3:0] e0 [4];
    logic [3:0] e1 [4];
    vals = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9};
    e0 = '{4'd1, 4'd2, 4'd3, 4'd4};
    e1 = '{4'd2, 4'd3, 4'd4, 4'd9};
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    foreach (vals[i]) begin
      tick(1, 0, vals[i], 0);
      tick(0, 0, vals[i], 0);
    end
    checks++; if (full0 !== 1'b1 || cnt0 !== 3'd4) begin errors++; $display("FAIL fill_full0: got full=%b cnt=%0d want 1/4", full0, cnt0); end
    checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL fill_ovf0: got %b want 1", ovf0); end
    checks++; if (seg0 !== 7'b0000110) begin errors++; $display("FAIL fill_seg0: got %b want 0000110", seg0); end
    checks++; if (cnt1 !== 3'd4 || ovf1 !== 1'b0) begin errors++; $display("FAIL fill_dut1: got cnt=%0d ovf=%b want 4/0", cnt1, ovf1); end
    checks++; if (seg1 !== 7'b1011011) begin errors++; $display("FAIL fill_seg1: got %b want 1011011", seg1); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (seg0 !== ref_seg(e0[i])) begin errors++; $display("FAIL pop_read0[%0d]: got %b want %b", i, seg0, ref_seg(e0[i])); end
      checks++; if (seg1 !== ref_seg(e1[i])) begin errors++; $display("FAIL pop_read1[%0d]: got %b want %b", i, seg1, ref_seg(e1[i])); end
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
    end
    checks++; if (seg1 !== DASH || empty1 !== 1'b1) begin errors++; $display("FAIL drain_dut1: got seg=%b empty=%b want 1000000/1", seg1, empty1); end
    checks++; if (unf1 !== 1'b0) begin errors++; $display("FAIL drain_unf1: got %b want 0", unf1); end
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    checks++; if (unf1 !== 1'b1 || cnt1 !== 3'd0) begin errors++; $display("FAIL underflow1: got unf=%b cnt=%0d want 1/0", unf1, cnt1); end
    checks++; if (unf0 !== 1'b1 || ovf0 !== 1'b1) begin errors++; $display("FAIL sticky0: got unf=%b ovf=%b want 1/1", unf0, ovf0); end
  endtask

  task automatic test_hold_and_wrap();
    logic [3:0] d;
    tick(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) tick(1, 0, 4'($urandom_range(0, 15)), 0);
    tick(0, 0, 0, 0);
    checks++; if (cnt0 !== 3'd1 || cnt1 !== 3'd1) begin errors++; $display("FAIL hold_count: got %0d/%0d want 1/1", cnt0, cnt1); end
    d = 4'($urandom_range(0, 15));
    tick(1, 0, d, 0);
    tick(0, 0, d, 0);
    for (int i = 0; i < 6; i++) begin
      d = 4'($urandom_range(0, 15));
      tick(1, 0, d, 0);
      tick(0, 0, d, 0);
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
      checks++; if (seg0 !== eseg0 || cnt0 !== 3'(q0.size())) begin errors++; $display("FAIL wrap_pair[%0d]: got seg=%b cnt=%0d want %b/%0d", i, seg0, cnt0, eseg0, q0.size()); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a, b, c;
    a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); c = 4'($urandom_range(0, 15));
    tick(0, 0, 0, 1);
    tick(1, 0, a, 0); tick(0, 0, a, 0);
    tick(1, 0, b, 0); tick(0, 0, b, 0);
    checks++; if (cnt0 !== 3'd2) begin errors++; $display("FAIL b2b_pre: got %0d want 2", cnt0); end
    tick(1, 1, c, 0);
    checks++; if (cnt0 !== 3'd2 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin errors++; $display("FAIL b2b_count: got cnt=%0d ovf=%b unf=%b want 2/0/0", cnt0, ovf0, unf0); end
    tick(0, 0, 0, 0);
    checks++; if (seg0 !== ref_seg(b)) begin errors++; $display("FAIL b2b_seg: got %b want %b", seg0, ref_seg(b)); end
    tick(0, 1, 0, 1);
    tick(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
    checks++; if (cnt0 !== 3'd0 || unf0 !== 1'b0 || empty0 !== 1'b1) begin errors++; $display("FAIL held_pop_reset: got cnt=%0d unf=%b empty=%b want 0/0/1", cnt0, unf0, empty0); end
    tick(0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [13:0] act, exp;
    tick(0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 99) == 0));
      act = {cnt0, full0, empty0, ovf0, unf0, seg0};
      exp = {3'(q0.size()), q0.size() == DEPTH, q0.size() == 0, m_ovf0, m_unf0, eseg0};
      checks++; if (act !== exp) begin errors++; $display("FAIL rand0[%0d]: got %h want %h", i, act, exp); end
      act = {cnt1, full1, empty1, ovf1, unf1, seg1};
      exp = {3'(q1.size()), q1.size() == DEPTH, q1.size() == 0, m_ovf1, m_unf1, eseg1};
      checks++; if (act !== exp) begin errors++; $display("FAIL rand1[%0d]: got %h want %h", i, act, exp); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_hold_and_wrap();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
